// File: rtl/tx_queue_arbiter.sv
// Round-robin scheduler: pops one word from the granted queue and offers it on tx_valid/tx_ready.
// Define TX_QUEUE_ARBITER_PRIORITY_EN to give queue 0 strict priority over the rotation.
module tx_queue_arbiter #(
  parameter int NUM_QUEUES  = 10,
  parameter int WORD_SIZE   = 4,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [NUM_QUEUES-1:0]           queue_not_empty,
  input  logic [NUM_QUEUES*WORD_SIZE-1:0] queue_data,
  output logic [NUM_QUEUES-1:0]           queue_read,
  output logic                            tx_valid,
  output logic [WORD_SIZE-1:0]            tx_data,
  input  logic                            tx_ready,
  output logic [INDEX_WIDTH-1:0]          grant_index,
  output logic                            busy
);

  typedef enum logic [1:0] {IDLE, GRANT, SEND} state_t;

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] idx;
    logic [WORD_SIZE-1:0]   data;
  } grant_t;

  localparam logic [INDEX_WIDTH-1:0] PTR_INIT = INDEX_WIDTH'(NUM_QUEUES - 1);

  state_t                                 state, state_nxt;
  logic [INDEX_WIDTH-1:0]                 rr_ptr;
  grant_t                                 win, held;
  logic                                   any_req, any_hi;
  logic [INDEX_WIDTH-1:0]                 hi_idx, lo_idx;
  logic [NUM_QUEUES-1:0]                  hi_req, win_oh;
  logic [NUM_QUEUES-1:0][WORD_SIZE-1:0]   q_word, sel_word;

  // Per-queue slot: qualify requests above the pointer and gate the winner's word.
  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_slot
    localparam logic [INDEX_WIDTH-1:0] IDX_W = INDEX_WIDTH'(g);
    assign q_word[g]   = queue_data[g*WORD_SIZE +: WORD_SIZE];
    assign hi_req[g]   = queue_not_empty[g] && (IDX_W > rr_ptr);
    assign sel_word[g] = win_oh[g] ? q_word[g] : '0;
  end

  assign any_req = |queue_not_empty;
  assign any_hi  = |hi_req;

  // Lowest set bit above the pointer wins; otherwise wrap to lowest set bit overall.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
      if (hi_req[i])          hi_idx = INDEX_WIDTH'(i);
      if (queue_not_empty[i]) lo_idx = INDEX_WIDTH'(i);
    end
  end

  always_comb begin
    win.idx = any_hi ? hi_idx : lo_idx;
`ifdef TX_QUEUE_ARBITER_PRIORITY_EN
    if (queue_not_empty[0]) win.idx = '0;
`endif
    win_oh = NUM_QUEUES'(1) << win.idx;
  end

  always_comb begin
    win.data = '0;
    for (int i = 0; i < NUM_QUEUES; i++) win.data = win.data | sel_word[i];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = GRANT;
      GRANT:   state_nxt = any_req ? SEND : IDLE;
      SEND:    if (tx_ready) state_nxt = any_req ? GRANT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    queue_read = '0;
    tx_valid   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      GRANT:   if (any_req) queue_read = win_oh;
      SEND:    tx_valid = 1'b1;
      default: ;
    endcase
  end

  // Latched word stays frozen for the whole SEND, whatever the queues do meanwhile.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      held   <= '0;
      rr_ptr <= PTR_INIT;
    end else begin
      if (state == GRANT && any_req) held <= win;
      if (state == SEND && tx_ready) begin
`ifdef TX_QUEUE_ARBITER_PRIORITY_EN
        // Queue-0 wins bypass the rotation so queues 1..N-1 keep their order.
        if (held.idx != '0) rr_ptr <= held.idx;
`else
        rr_ptr <= held.idx;
`endif
      end
    end
  end

  assign tx_data     = held.data;
  assign grant_index = held.idx;

endmodule
